// File: rtl/modulo_captura_jogada_if.sv
// Command handshake between the play-capture block and the game core.
// The master drives a pending command; the slave accepts it with cmd_ready.
interface modulo_captura_jogada_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_line;
    logic [2:0] cmd_col;
    logic       cmd_err;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_line,
        output cmd_col,
        output cmd_err,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_line,
        input  cmd_col,
        input  cmd_err,
        output cmd_ready
    );
endinterface

// File: rtl/modulo_captura_jogada.sv
// Captures a player move: synchronizes and debounces the confirm button, latches switches on press.
// Optional macro CAPTURA_DUP_FILTER_EN drops repeated attacks on the last transferred coordinate.
module modulo_captura_jogada #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            button_confirmation,
    input  logic [1:0]                      hh1,
    input  logic [5:0]                      hh2,
    modulo_captura_jogada_if.master         cmd,
    output logic                            ovr
);

    localparam int              CNT_W    = 20;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [1:0]      MODE_IDLE   = 2'b00;
    localparam logic [1:0]      MODE_ATTACK = 2'b10;

    typedef enum logic {IDLE, HOLD} state_t;

    // The board is 7 lines by 5 columns; line 7 and columns 5..7 do not exist.
    function automatic logic coord_err(input logic [2:0] line, input logic [2:0] col);
        coord_err = (line == 3'd7) || (col > 3'd4);
    endfunction

    logic                btn_s1, btn_s2;
    logic [1:0]          hh1_s1, hh1_s2;
    logic [5:0]          hh2_s1, hh2_s2;
    logic                deb_lvl, deb_prev;
    logic [CNT_W-1:0]    deb_cnt;
    logic                press_evt;
    logic                dup_hit;
    logic                accept;
    state_t              state, state_nxt;
    logic                valid_c, load_c, xfer_c, ovr_set_c;
    logic [1:0]          mode_q;
    logic [2:0]          line_q, col_q;
    logic                err_q;

    // Synchronizer stage: button idles high (released), switches idle at zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            hh1_s1 <= '0;
            hh1_s2 <= '0;
            hh2_s1 <= '0;
            hh2_s2 <= '0;
        end else begin
            btn_s1 <= button_confirmation;
            btn_s2 <= btn_s1;
            hh1_s1 <= hh1;
            hh1_s2 <= hh1_s1;
            hh2_s1 <= hh2;
            hh2_s2 <= hh2_s1;
        end
    end

    // Debounce stage: level follows the button only after DEB_CYCLES of disagreement
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            deb_lvl  <= 1'b1;
            deb_prev <= 1'b1;
            deb_cnt  <= '0;
        end else begin
            deb_prev <= deb_lvl;
            if (btn_s2 != deb_lvl) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_lvl <= btn_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Only the released-to-pressed transition is an event.
    assign press_evt = deb_prev & ~deb_lvl;

`ifdef CAPTURA_DUP_FILTER_EN
    logic       last_vld;
    logic [5:0] last_coord;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_vld   <= 1'b0;
            last_coord <= '0;
        end else if (xfer_c && (mode_q == MODE_ATTACK)) begin
            last_vld   <= 1'b1;
            last_coord <= {line_q, col_q};
        end
    end

    assign dup_hit = last_vld && (hh1_s2 == MODE_ATTACK) && (hh2_s2 == last_coord);
`else
    assign dup_hit = 1'b0;
`endif

    assign accept = press_evt && (hh1_s2 != MODE_IDLE) && !dup_hit;

    // Command FSM stage
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = HOLD;
            HOLD:    if (cmd.cmd_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_c   = (state == HOLD);
        load_c    = (state == IDLE) && accept;
        xfer_c    = (state == HOLD) && cmd.cmd_ready;
        // A press that lands on the transfer edge still sees HOLD and is dropped.
        ovr_set_c = (state == HOLD) && press_evt;
    end

    // Payload stage: frozen for the whole time the command is pending
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q <= '0;
            line_q <= '0;
            col_q  <= '0;
            err_q  <= 1'b0;
        end else if (load_c) begin
            mode_q <= hh1_s2;
            line_q <= hh2_s2[5:3];
            col_q  <= hh2_s2[2:0];
            err_q  <= coord_err(hh2_s2[5:3], hh2_s2[2:0]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)            ovr <= 1'b0;
        else if (ovr_set_c) ovr <= 1'b1;
    end

    assign cmd.cmd_valid = valid_c;
    assign cmd.cmd_mode  = mode_q;
    assign cmd.cmd_line  = line_q;
    assign cmd.cmd_col   = col_q;
    assign cmd.cmd_err   = err_q;

endmodule

// File: tb/tb_modulo_captura_jogada.sv
// Scoreboard bench for modulo_captura_jogada with a short debounce window.
module tb_modulo_captura_jogada;
  localparam int DEB = 4;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] line;
    logic [2:0] col;
    logic       err;
  } cmd_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn = 1'b1;
  logic [1:0] hh1 = '0;
  logic [5:0] hh2 = '0;
  logic       ovr;
  int         checks = 0;
  int         errors = 0;
  cmd_t       exp_q[$];

  modulo_captura_jogada_if cmd_if();

  modulo_captura_jogada #(.DEB_CYCLES(DEB)) dut (
    .clk(clk),
    .clr(clr),
    .button_confirmation(btn),
    .hh1(hh1),
    .hh2(hh2),
    .cmd(cmd_if.master),
    .ovr(ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cmd_t mk(input logic [1:0] m, input logic [2:0] l, input logic [2:0] c);
    cmd_t r;
    r.mode = m;
    r.line = l;
    r.col  = c;
    r.err  = (l == 3'd7) || (c > 3'd4);
    return r;
  endfunction

  function automatic cmd_t observed();
    cmd_t r;
    r = {cmd_if.cmd_mode, cmd_if.cmd_line, cmd_if.cmd_col, cmd_if.cmd_err};
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick(1);
      if (cmd_if.cmd_valid === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic release_btn();
    btn = 1'b1;
    tick(DEB + 4);
  endtask

  task automatic test_reset();
    cmd_t z = '0;
    clr = 1'b1;
    cmd_if.cmd_ready = 1'b0;
    tick(3);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b ovr=%b expected 0 0", cmd_if.cmd_valid, ovr);
    end
    checks++;
    if (observed() !== z) begin
      errors++;
      $display("FAIL reset_payload: got %h expected %h", observed(), z);
    end
    clr = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int k;
    cmd_t e;
    hh1 = 2'b01;
    hh2 = 6'b010_011;
    cmd_if.cmd_ready = 1'b1;
    tick(3);
    exp_q.push_back(mk(2'b01, 3'd2, 3'd3));
    btn = 1'b0;
    wait_valid(20, k);
    checks++;
    if (k != DEB + 3) begin
      errors++;
      $display("FAIL basic_latency: valid on edge %0d expected %0d", k, DEB + 3);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_payload: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL basic_payload: got %h expected %h", observed(), e);
      end
    end
    tick(1);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle: valid=%b expected 0", cmd_if.cmd_valid);
    end
    release_btn();
  endtask

  task automatic test_bounce();
    int nv = 0;
    cmd_t e, got = '0;
    hh1 = 2'b01;
    hh2 = 6'b001_100;
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn = ((i >> 1) & 1) ? 1'b1 : 1'b0;
      tick(1);
      if (cmd_if.cmd_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL bounce_quiet: %0d valid cycles expected 0", nv);
    end
    exp_q.push_back(mk(2'b01, 3'd1, 3'd4));
    btn = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (cmd_if.cmd_valid === 1'b1) begin
        if (nv == 0) got = observed();
        nv++;
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL bounce_single: %0d valid cycles expected 1", nv);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL bounce_payload: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL bounce_payload: got %h expected %h", got, e);
      end
    end
    release_btn();
  endtask

  task automatic test_hold_ovr();
    int k;
    cmd_t e = '0;
    cmd_if.cmd_ready = 1'b0;
    hh1 = 2'b10;
    hh2 = 6'b111_101;
    tick(3);
    exp_q.push_back(mk(2'b10, 3'd7, 3'd5));
    btn = 1'b0;
    wait_valid(20, k);
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL hold_valid: no valid within 20 cycles expected valid");
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL hold_payload: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL hold_payload: got %h expected %h", observed(), e);
      end
    end
    hh1 = 2'b01;
    hh2 = 6'b000_000;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (cmd_if.cmd_valid !== 1'b1 || observed() !== e) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b got %h expected 1 %h",
                 i, cmd_if.cmd_valid, observed(), e);
      end
    end
    btn = 1'b1;
    tick(DEB + 4);
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_no_ovr: ovr=%b expected 0", ovr);
    end
    btn = 1'b0;
    tick(DEB + 6);
    checks++;
    if (ovr !== 1'b1 || cmd_if.cmd_valid !== 1'b1 || observed() !== e) begin
      errors++;
      $display("FAIL hold_second_press: ovr=%b valid=%b got %h expected 1 1 %h",
               ovr, cmd_if.cmd_valid, observed(), e);
    end
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    cmd_if.cmd_ready = 1'b0;
    tick(5);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_dropped: valid=%b expected 0", cmd_if.cmd_valid);
    end
    release_btn();
  endtask

  task automatic test_idle_mode();
    int nv = 0;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL idle_ovr_cleared: ovr=%b expected 0", ovr);
    end
    hh1 = 2'b00;
    hh2 = 6'b010_010;
    cmd_if.cmd_ready = 1'b1;
    tick(3);
    btn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (cmd_if.cmd_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignored: valid cycles=%0d ovr=%b expected 0 0", nv, ovr);
    end
    release_btn();
  endtask

  task automatic test_collision();
    int k;
    cmd_t e;
    cmd_if.cmd_ready = 1'b0;
    hh1 = 2'b01;
    hh2 = 6'b000_001;
    tick(3);
    exp_q.push_back(mk(2'b01, 3'd0, 3'd1));
    btn = 1'b0;
    wait_valid(20, k);
    checks++;
    if (exp_q.size() == 0 || k < 0) begin
      errors++;
      $display("FAIL collide_first: k=%0d queue=%0d expected valid and entry", k, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL collide_first: got %h expected %h", observed(), e);
      end
    end
    btn = 1'b1;
    tick(DEB + 4);
    btn = 1'b0;
    tick(DEB + 2);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    cmd_if.cmd_ready = 1'b0;
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || ovr !== 1'b1) begin
      errors++;
      $display("FAIL collide_edge: valid=%b ovr=%b expected 0 1", cmd_if.cmd_valid, ovr);
    end
    tick(10);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_no_cmd: valid=%b expected 0", cmd_if.cmd_valid);
    end
    release_btn();
  endtask

  task automatic test_reset_in_hold();
    int k;
    cmd_t e, z = '0;
    cmd_if.cmd_ready = 1'b0;
    hh1 = 2'b11;
    hh2 = 6'b100_010;
    tick(3);
    exp_q.push_back(mk(2'b11, 3'd4, 3'd2));
    btn = 1'b0;
    wait_valid(20, k);
    checks++;
    if (exp_q.size() == 0 || k < 0) begin
      errors++;
      $display("FAIL rsthold_cmd: k=%0d queue=%0d expected valid and entry", k, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL rsthold_cmd: got %h expected %h", observed(), e);
      end
    end
    #2;
    clr = 1'b1;
    btn = 1'b1;
    #1;
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || ovr !== 1'b0 || observed() !== z) begin
      errors++;
      $display("FAIL rsthold_async: valid=%b ovr=%b got %h expected 0 0 %h",
               cmd_if.cmd_valid, ovr, observed(), z);
    end
    tick(2);
    clr = 1'b0;
    tick(DEB + 4);
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsthold_after: valid=%b expected 0", cmd_if.cmd_valid);
    end
  endtask

  task automatic test_held_reset();
    int k, nv = 0;
    cmd_t e;
    btn = 1'b0;
    hh1 = 2'b01;
    hh2 = 6'b011_000;
    cmd_if.cmd_ready = 1'b1;
    clr = 1'b1;
    tick(2);
    exp_q.push_back(mk(2'b01, 3'd3, 3'd0));
    clr = 1'b0;
    wait_valid(20, k);
    checks++;
    if (k != DEB + 3) begin
      errors++;
      $display("FAIL held_latency: valid on edge %0d expected %0d", k, DEB + 3);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL held_payload: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (observed() !== e) begin
        errors++;
        $display("FAIL held_payload: got %h expected %h", observed(), e);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (cmd_if.cmd_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL held_single: extra valid cycles=%0d expected 0", nv);
    end
    release_btn();
  endtask

  task automatic test_dup_attack();
    int k, nv = 0;
    cmd_t e;
    cmd_if.cmd_ready = 1'b1;
    hh1 = 2'b10;
    hh2 = 6'b001_001;
    for (int p = 0; p < 3; p++) begin
      if (p == 2) hh2 = 6'b001_010;
      tick(3);
`ifdef CAPTURA_DUP_FILTER_EN
      if (p != 1) exp_q.push_back(mk(2'b10, 3'd1, hh2[2:0]));
`else
      exp_q.push_back(mk(2'b10, 3'd1, hh2[2:0]));
`endif
      btn = 1'b0;
      wait_valid(DEB + 10, k);
      checks++;
      if (k < 0) begin
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL dup_press%0d: no valid with %0d pending expected command", p, exp_q.size());
        end
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dup_press%0d: valid with payload %h expected none", p, observed());
      end else begin
        e = exp_q.pop_front();
        if (observed() !== e) begin
          errors++;
          $display("FAIL dup_press%0d: got %h expected %h", p, observed(), e);
        end
      end
      if (cmd_if.cmd_valid === 1'b1) nv++;
      release_btn();
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL dup_ovr: ovr=%b expected 0", ovr);
    end
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_basic();
    test_bounce();
    test_hold_ovr();
    test_idle_mode();
    test_collision();
    test_reset_in_hold();
    test_held_reset();
    test_dup_attack();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
